// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external single-cycle ALU between two requesters.
//   A round-robin grant picks a requester in IDLE. Its operands are latched
//   into registers that drive the ALU directly. The ALU result and flags are
//   captured one cycle later and returned on the winner's response channel.
//   Only one operation is in flight at a time.
//
//   Optional feature macro: ALU_ARB_ILLEGAL_OP_EN
//     When defined, alufn codes 0010, 0110, 1011, 1100 and 1110 are illegal.
//     An illegal op follows the normal FSM path and latency. The ALU sees
//     alufn 0000. The response returns r=0, flags=0 and err=1.
//     When undefined, all codes pass through and err is tied low.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | grant logic active; an accepted request latches operands
// EXEC  | latched operands at the ALU; result/flags captured at the edge
// RESP  | resp<g>_valid high for the winner until its resp_ready

module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [3:0]      req0_alufn_i,
    input  logic [XLEN-1:0] req0_a_i,
    input  logic [XLEN-1:0] req0_b_i,
    input  logic [4:0]      req0_shamt_i,

    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [3:0]      req1_alufn_i,
    input  logic [XLEN-1:0] req1_a_i,
    input  logic [XLEN-1:0] req1_b_i,
    input  logic [4:0]      req1_shamt_i,

    output logic            resp0_valid_o,
    input  logic            resp0_ready_i,
    output logic [XLEN-1:0] resp0_r_o,
    output logic [3:0]      resp0_flags_o,
    output logic            resp0_err_o,

    output logic            resp1_valid_o,
    input  logic            resp1_ready_i,
    output logic [XLEN-1:0] resp1_r_o,
    output logic [3:0]      resp1_flags_o,
    output logic            resp1_err_o,

    output logic [3:0]      alu_alufn_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [4:0]      alu_shamt_o,
    input  logic [XLEN-1:0] alu_r_i,
    input  logic            alu_zf_i,
    input  logic            alu_cf_i,
    input  logic            alu_vf_i,
    input  logic            alu_sf_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic              ptr_q;
    logic              gnt_q;
    logic              ill_q;

    logic [3:0]        alufn_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [4:0]        shamt_q;

    logic [XLEN-1:0]   r_q;
    logic [3:0]        flags_q;
    logic              err_q;
    logic              resp0_valid_q;
    logic              resp1_valid_q;

    logic              win_any;
    logic              win_id;
    logic              resp_hs;

    logic [3:0]        req_alufn_d;
    logic [XLEN-1:0]   req_a_d;
    logic [XLEN-1:0]   req_b_d;
    logic [4:0]        req_shamt_d;
    logic              req_ill_d;

    // Round-robin grant: a lone requester wins, a tie goes to ptr_q.
    // Held off in reset so ready never rises while rst_ni is low.
    always_comb begin
        win_any = 1'b0;
        win_id  = 1'b0;
        if (rst_ni && (state_q == ST_IDLE)) begin
            win_any = req0_valid_i | req1_valid_i;
            if (req0_valid_i && req1_valid_i) begin
                win_id = ptr_q;
            end else begin
                win_id = req1_valid_i;
            end
        end
    end

    assign req0_ready_o = win_any & ~win_id;
    assign req1_ready_o = win_any &  win_id;

    // Operand mux from the winning requester, ready to be latched on accept.
    always_comb begin
        req_alufn_d = req0_alufn_i;
        req_a_d     = req0_a_i;
        req_b_d     = req0_b_i;
        req_shamt_d = req0_shamt_i;
        if (win_id) begin
            req_alufn_d = req1_alufn_i;
            req_a_d     = req1_a_i;
            req_b_d     = req1_b_i;
            req_shamt_d = req1_shamt_i;
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    // Illegal function decode for the winner's alufn.
    always_comb begin
        req_ill_d = 1'b0;
        case (req_alufn_d)
            4'b0010, 4'b0110, 4'b1011, 4'b1100, 4'b1110: req_ill_d = 1'b1;
            default:                                     req_ill_d = 1'b0;
        endcase
    end
`else
    assign req_ill_d = 1'b0;
`endif

    assign resp_hs = (resp0_valid_q & resp0_ready_i) |
                     (resp1_valid_q & resp1_ready_i);

    // Sequencing FSM with operand latches, result capture and pointer update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 1'b0;
            gnt_q         <= 1'b0;
            ill_q         <= 1'b0;
            alufn_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            shamt_q       <= '0;
            r_q           <= '0;
            flags_q       <= '0;
            err_q         <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_any) begin
                        // Illegal ops still run through the ALU, but as a
                        // harmless code 0000; the capture stage masks the result.
                        alufn_q <= req_ill_d ? 4'b0000 : req_alufn_d;
                        a_q     <= req_a_d;
                        b_q     <= req_b_d;
                        shamt_q <= req_shamt_d;
                        gnt_q   <= win_id;
                        ill_q   <= req_ill_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_q           <= ill_q ? '0 : alu_r_i;
                    flags_q       <= ill_q ? 4'b0000
                                           : {alu_zf_i, alu_cf_i, alu_vf_i, alu_sf_i};
                    err_q         <= ill_q;
                    resp0_valid_q <= ~gnt_q;
                    resp1_valid_q <=  gnt_q;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_hs) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        ptr_q         <= ~gnt_q;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    resp0_valid_q <= 1'b0;
                    resp1_valid_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_alufn_o   = alufn_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_shamt_o   = shamt_q;

    // Result data is shared by both channels; only resp<g>_valid qualifies it.
    assign resp0_valid_o = resp0_valid_q;
    assign resp0_r_o     = r_q;
    assign resp0_flags_o = flags_q;
    assign resp0_err_o   = err_q;

    assign resp1_valid_o = resp1_valid_q;
    assign resp1_r_o     = r_q;
    assign resp1_flags_o = flags_q;
    assign resp1_err_o   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with a small behavioural ALU attached to alu_*.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_alufn, req1_alufn;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;

    logic        resp0_valid, resp0_ready, resp0_err;
    logic        resp1_valid, resp1_ready, resp1_err;
    logic [31:0] resp0_r, resp1_r;
    logic [3:0]  resp0_flags, resp1_flags;

    logic [3:0]  alu_alufn;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [4:0]  alu_shamt;
    logic        alu_zf, alu_cf, alu_vf, alu_sf;

    logic [32:0] m_sum;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic        id;
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r;
        logic [3:0]  fl;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req0_valid_i  (req0_valid),
        .req0_ready_o  (req0_ready),
        .req0_alufn_i  (req0_alufn),
        .req0_a_i      (req0_a),
        .req0_b_i      (req0_b),
        .req0_shamt_i  (req0_shamt),
        .req1_valid_i  (req1_valid),
        .req1_ready_o  (req1_ready),
        .req1_alufn_i  (req1_alufn),
        .req1_a_i      (req1_a),
        .req1_b_i      (req1_b),
        .req1_shamt_i  (req1_shamt),
        .resp0_valid_o (resp0_valid),
        .resp0_ready_i (resp0_ready),
        .resp0_r_o     (resp0_r),
        .resp0_flags_o (resp0_flags),
        .resp0_err_o   (resp0_err),
        .resp1_valid_o (resp1_valid),
        .resp1_ready_i (resp1_ready),
        .resp1_r_o     (resp1_r),
        .resp1_flags_o (resp1_flags),
        .resp1_err_o   (resp1_err),
        .alu_alufn_o   (alu_alufn),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_shamt_o   (alu_shamt),
        .alu_r_i       (alu_r),
        .alu_zf_i      (alu_zf),
        .alu_cf_i      (alu_cf),
        .alu_vf_i      (alu_vf),
        .alu_sf_i      (alu_sf)
    );

    // Behavioural ALU: add, sub, and, or, xor, pass-b, sll, srl.
    always_comb begin
        m_sum  = '0;
        alu_r  = '0;
        alu_cf = 1'b0;
        alu_vf = 1'b0;
        case (alu_alufn)
            4'b0000: begin
                m_sum  = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r  = m_sum[31:0];
                alu_cf = m_sum[32];
                alu_vf = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0001: begin
                alu_r  = alu_a - alu_b;
                alu_cf = alu_a < alu_b;
                alu_vf = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0011: alu_r = alu_a & alu_b;
            4'b0100: alu_r = alu_a | alu_b;
            4'b0101: alu_r = alu_a ^ alu_b;
            4'b0110: alu_r = alu_b;
            4'b0111: alu_r = alu_a << alu_shamt;
            4'b1000: alu_r = alu_a >> alu_shamt;
            default: alu_r = '0;
        endcase
    end
    assign alu_zf = (alu_r == 32'd0);
    assign alu_sf = alu_r[31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic vld, input logic [3:0] fn,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        if (!id) begin
            req0_valid = vld; req0_alufn = fn; req0_a = a; req0_b = b; req0_shamt = sh;
        end else begin
            req1_valid = vld; req1_alufn = fn; req1_a = a; req1_b = b; req1_shamt = sh;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated op on one requester with zero backpressure.
    task automatic run_vec(input int k, input vec_t v);
        int   acc_c;
        int   rv_c;
        bit   got;
        logic [3:0] exp_fn;
        exp_fn = v.err ? 4'b0000 : v.fn;
        acc_c = 0;
        rv_c  = 0;
        @(negedge clk);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        drive_req(v.id, 1'b1, v.fn, v.a, v.b, v.sh);
        got = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if ((v.id ? req1_ready : req0_ready) === 1'b1) begin
                got = 1; acc_c = cyc; break;
            end
            @(negedge clk);
        end
        chkb($sformatf("v%0d_accept", k), got, 1'b1);
        @(negedge clk);
        drive_req(v.id, 1'b0, v.fn, v.a, v.b, v.sh);
        #1;
        chk($sformatf("v%0d_alu_a", k), alu_a, v.a);
        chk($sformatf("v%0d_alu_b", k), alu_b, v.b);
        chk($sformatf("v%0d_alu_shamt", k), 32'(alu_shamt), 32'(v.sh));
        chk($sformatf("v%0d_alu_fn", k), 32'(alu_alufn), 32'(exp_fn));
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if ((v.id ? resp1_valid : resp0_valid) === 1'b1) begin
                got = 1; rv_c = cyc; break;
            end
            @(negedge clk);
            #1;
        end
        chkb($sformatf("v%0d_resp_valid", k), got, 1'b1);
        chk($sformatf("v%0d_latency", k), 32'(rv_c - acc_c), 32'd2);
        chk($sformatf("v%0d_r", k), v.id ? resp1_r : resp0_r, v.r);
        chk($sformatf("v%0d_flags", k), 32'(v.id ? resp1_flags : resp0_flags), 32'(v.fl));
        chkb($sformatf("v%0d_err", k), v.id ? resp1_err : resp0_err, v.err);
        chkb($sformatf("v%0d_other_valid", k), v.id ? resp0_valid : resp1_valid, 1'b0);
        @(negedge clk);
        #1;
        chkb($sformatf("v%0d_valid_drop", k), v.id ? resp1_valid : resp0_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, k1, s0, s1, g;

        vecs[0]  = '{id:1'b0, fn:4'b0000, a:32'd5,          b:32'd7,          sh:5'd0,  r:32'd12,         fl:4'b0000, err:1'b0};
        vecs[1]  = '{id:1'b1, fn:4'b0001, a:32'd3,          b:32'd3,          sh:5'd0,  r:32'd0,          fl:4'b1000, err:1'b0};
        vecs[2]  = '{id:1'b1, fn:4'b0001, a:32'h7FFF_FFFF,  b:32'hFFFF_FFFF,  sh:5'd0,  r:32'h8000_0000,  fl:4'b0111, err:1'b0};
        vecs[3]  = '{id:1'b0, fn:4'b0000, a:32'hFFFF_FFFF,  b:32'd1,          sh:5'd0,  r:32'd0,          fl:4'b1100, err:1'b0};
        vecs[4]  = '{id:1'b0, fn:4'b0011, a:32'hF0F0_00FF,  b:32'h0FF0_0F0F,  sh:5'd0,  r:32'h00F0_000F,  fl:4'b0000, err:1'b0};
        vecs[5]  = '{id:1'b1, fn:4'b0100, a:32'h8000_0000,  b:32'd1,          sh:5'd0,  r:32'h8000_0001,  fl:4'b0001, err:1'b0};
        vecs[6]  = '{id:1'b0, fn:4'b0101, a:32'h1234_5678,  b:32'h1234_5678,  sh:5'd0,  r:32'd0,          fl:4'b1000, err:1'b0};
        vecs[7]  = '{id:1'b1, fn:4'b0111, a:32'h0000_00F1,  b:32'd0,          sh:5'd4,  r:32'h0000_0F10,  fl:4'b0000, err:1'b0};
        vecs[8]  = '{id:1'b0, fn:4'b1000, a:32'h8000_0000,  b:32'd0,          sh:5'd31, r:32'd1,          fl:4'b0000, err:1'b0};
`ifdef ALU_ARB_ILLEGAL_OP_EN
        vecs[9]  = '{id:1'b1, fn:4'b0110, a:32'd9,          b:32'h55,         sh:5'd0,  r:32'd0,          fl:4'b0000, err:1'b1};
        vecs[10] = '{id:1'b0, fn:4'b1110, a:32'd1,          b:32'd2,          sh:5'd3,  r:32'd0,          fl:4'b0000, err:1'b1};
`else
        vecs[9]  = '{id:1'b1, fn:4'b0110, a:32'd9,          b:32'h55,         sh:5'd0,  r:32'h55,         fl:4'b0000, err:1'b0};
        vecs[10] = '{id:1'b0, fn:4'b1110, a:32'd1,          b:32'd2,          sh:5'd3,  r:32'd0,          fl:4'b1000, err:1'b0};
`endif

        // Reset with a pending request: no ready, outputs cleared.
        rst_n = 1'b0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        drive_req(1'b0, 1'b1, 4'b0000, 32'd1, 32'd2, 5'd0);
        drive_req(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        repeat (3) @(negedge clk);
        #1;
        chkb("rst_req0_ready", req0_ready, 1'b0);
        chkb("rst_req1_ready", req1_ready, 1'b0);
        chkb("rst_resp0_valid", resp0_valid, 1'b0);
        chkb("rst_resp1_valid", resp1_valid, 1'b0);
        chk("rst_resp0_r", resp0_r, 32'd0);
        chk("rst_resp0_flags", 32'(resp0_flags), 32'd0);
        chkb("rst_resp0_err", resp0_err, 1'b0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_fn", 32'(alu_alufn), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chkb("rst_release_ready", req0_ready, 1'b1);
        req0_valid = 1'b0;

        // Table-driven single ops.
        for (int k = 0; k < 11; k++) run_vec(k, vecs[k]);

        // Contention: both requesters continuously valid, four ops each.
        do_reset();
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        k0 = 0; k1 = 0; s0 = 0; s1 = 0; g = 0;
        for (int c = 0; c < 80 && (s0 < 4 || s1 < 4); c++) begin
            @(negedge clk);
            drive_req(1'b0, k0 < 4, 4'b0000, 32'(k0 + 1), 32'd100, 5'd0);
            drive_req(1'b1, k1 < 4, 4'b0001, 32'd1000, 32'(k1), 5'd0);
            #1;
            if (resp0_valid) begin
                chk("cont_r0", resp0_r, 32'(101 + s0));
                chkb("cont_excl0", resp1_valid, 1'b0);
                s0++;
            end
            if (resp1_valid) begin
                chk("cont_r1", resp1_r, 32'(1000 - s1));
                s1++;
            end
            if (req0_ready || req1_ready) begin
                chkb("cont_gnt_order", req1_ready, g[0]);
                chkb("cont_one_ready", req0_ready & req1_ready, 1'b0);
                g++;
                if (req0_ready) k0++; else k1++;
            end
        end
        chk("cont_resp_count", 32'(s0 + s1), 32'd8);
        chk("cont_grant_count", 32'(g), 32'd8);

        // Backpressure on resp0 while req1 waits; req0 re-requests meanwhile.
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b1;
        drive_req(1'b0, 1'b1, 4'b0000, 32'd20, 32'd22, 5'd0);
        drive_req(1'b1, 1'b1, 4'b0011, 32'hFF, 32'h0F, 5'd0);
        #1;
        chkb("bp_gnt0", req0_ready, 1'b1);
        chkb("bp_no_gnt1", req1_ready, 1'b0);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 4'b0000, 32'd20, 32'd22, 5'd0);
        @(negedge clk);
        drive_req(1'b0, 1'b1, 4'b0000, 32'd1, 32'd1, 5'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chkb("bp_hold_valid", resp0_valid, 1'b1);
            chk("bp_hold_r", resp0_r, 32'd42);
            chkb("bp_req1_blocked", req1_ready, 1'b0);
            chkb("bp_req0_blocked", req0_ready, 1'b0);
            @(negedge clk);
        end
        resp0_ready = 1'b1;
        #1;
        chkb("bp_hs_valid", resp0_valid, 1'b1);
        chkb("bp_hs_req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        #1;
        chkb("bp_after_gnt1", req1_ready, 1'b1);
        chkb("bp_after_no_gnt0", req0_ready, 1'b0);
        chkb("bp_after_valid_low", resp0_valid, 1'b0);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 4'b0011, 32'hFF, 32'h0F, 5'd0);
        @(negedge clk);
        #1;
        chkb("bp_resp1_valid", resp1_valid, 1'b1);
        chk("bp_resp1_r", resp1_r, 32'h0F);
        @(negedge clk);
        #1;
        chkb("bp_req0_gnt_next", req0_ready, 1'b1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 4'b0000, 32'd1, 32'd1, 5'd0);
        @(negedge clk);
        #1;
        chkb("bp_resp0_valid2", resp0_valid, 1'b1);
        chk("bp_resp0_r2", resp0_r, 32'd2);

        // Reset during EXEC aborts the op with no response.
        @(negedge clk);
        drive_req(1'b1, 1'b1, 4'b0001, 32'd10, 32'd4, 5'd0);
        #1;
        chkb("mid_accept", req1_ready, 1'b1);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 4'b0001, 32'd10, 32'd4, 5'd0);
        rst_n = 1'b0;
        #1;
        chkb("mid_rst_valid", resp1_valid, 1'b0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_r", resp1_r, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chkb("mid_no_resp1", resp1_valid, 1'b0);
            chkb("mid_no_resp0", resp0_valid, 1'b0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
